pin_entry: RTL
==============

# pin_entry

Keypad PIN-entry and verification stage sitting directly upstream of the ATM transaction controller. It collects decimal digits from a keypad while a card is inserted and compares them against the stored PIN. It reports a one-cycle verdict (`pin_done` and `pin_correct`) that the controller consumes in its PIN-check state. It also enforces a retry limit with permanent lockout and an optional inactivity timeout.

## Interface
- `PIN_DIGITS`, default 4: number of BCD digits in a PIN.
- `MAX_TRIES`, default 3: failed attempts before lockout.
- `TIMEOUT_CYCLES`, default 1000: idle cycles in COLLECT before abort (only used with the timeout feature).

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `card_inserted` input 1: level, high while a card is present.
- `key_valid` input 1: one-cycle strobe; `key_digit` is valid.
- `key_digit` input 4: BCD digit.
- `key_enter` input 1: one-cycle strobe; submit entry.
- `key_clear` input 1: one-cycle strobe; discard digits entered so far.
- `stored_pin` input 4*PIN_DIGITS: reference PIN; the most significant nibble is the first digit.
- `pin_done` output 1: one-cycle verdict strobe.
- `pin_correct` output 1: verdict; meaningful when `pin_done`=1, otherwise 0.
- `locked` output 1: lockout flag, sticky.
- `timeout` output 1: one-cycle strobe on inactivity abort.
- `digit_count` output $clog2(PIN_DIGITS+1): digits currently buffered.

## Operation
- All outputs are registered. Reset values: `pin_done`=0, `pin_correct`=0, `locked`=0, `timeout`=0, `digit_count`=0. The try counter and the digit buffer also reset to 0, and the FSM resets to IDLE.
- IDLE:
  - On `card_inserted`=1, go to COLLECT with the buffer and `digit_count` cleared.
- COLLECT:
  - Same-cycle priority: `key_clear` > `key_enter` > `key_valid`.
  - `key_clear`: `digit_count` becomes 0.
  - `key_valid` with `key_digit`≤9 and `digit_count`<PIN_DIGITS: shift the digit into the buffer (left shift by 4) and increment `digit_count`.
  - `key_valid` with `key_digit`>9, or with the buffer already full: ignore.
  - `key_enter`: go to COMPARE. If `digit_count`≠PIN_DIGITS, the compare is forced to fail.
- COMPARE (one cycle): match = (`digit_count`==PIN_DIGITS) && (buffer==`stored_pin`). Go to RESULT.
- RESULT (one cycle): drive `pin_done`=1 and `pin_correct`=match.
  - On a match, clear the try counter and go to WAIT_REMOVE.
  - On a mismatch, increment the try counter. If it reaches MAX_TRIES, go to LOCKED. Otherwise return to COLLECT with `digit_count`=0.
- WAIT_REMOVE: hold until `card_inserted`=0, then go to IDLE. Keys are ignored in this state.
- LOCKED: `locked`=1 and all keys are ignored. Only `reset` exits this state, and `card_inserted` has no effect.
- Card removal (`card_inserted`=0) in COLLECT or COMPARE aborts to IDLE. The buffer is cleared, no verdict is issued, and the try counter is retained.
  - The try counter is retained across card sessions and clears only on a successful match or on reset.

## Timing
- A digit sampled at edge t appears in `digit_count` after edge t.
- `key_enter` sampled at edge t produces `pin_done` high in the cycle after edge t+2, for exactly one cycle.
- `locked` rises in the same cycle that `pin_done` reports the MAX_TRIES-th failure, and stays high.
- Reset asserted in any state returns all state and outputs to their reset values immediately (asynchronous). Deassertion is synchronous to `clk`.
- `stored_pin` must be stable from `key_enter` until `pin_done`.

## Configuration
- `PIN_TIMEOUT_EN` defined:
  - An inactivity counter runs in COLLECT and reloads on any `key_valid`, `key_enter` or `key_clear` strobe, ignored digits included.
  - After TIMEOUT_CYCLES cycles with no strobe, the block pulses `timeout` for one cycle and goes to IDLE. No verdict is issued and no try is charged.
- `PIN_TIMEOUT_EN` undefined: no counter is built, `timeout` is tied to 0, and COLLECT waits indefinitely.

## Test plan
- Correct PIN: `stored_pin`=16'h1234; insert card, keys 1,2,3,4, enter → `pin_done`=1 and `pin_correct`=1 two cycles after the enter edge, then WAIT_REMOVE. Removing the card returns to IDLE.
- Lockout: keys 9,9,9,9 + enter three times → `pin_correct`=0 on each verdict, and `locked`=1 with the third `pin_done`. A later correct entry produces no `pin_done`.
- Clear and short entry: keys 1,2, clear, 1,2,3,4, enter → pass. Keys 1,2,3, enter → fail with the try counter at 1. Digit 4'hA and a fifth digit are ignored (`digit_count` stays 4).
- Same-cycle strobes: `key_enter` and `key_valid` in the same cycle with 3 digits buffered → fail (enter wins; the digit is dropped). `key_clear` and `key_enter` in the same cycle → `digit_count`=0 and no verdict.
- Abort and reset: card removed after 2 digits → IDLE with no `pin_done`. Reset pulsed low during COMPARE → every output reads 0 and the FSM is in IDLE.
- With `PIN_TIMEOUT_EN` and TIMEOUT_CYCLES=10: insert card, enter 1 digit, then hold idle 10 cycles → `timeout` pulses once, FSM goes to IDLE, try counter unchanged.

Source files
------------

// File: rtl/pin_entry.sv
// pin_entry: keypad PIN collection and verification stage ahead of the ATM
// transaction controller. Buffers BCD digits while a card is present, compares
// them against stored_pin, issues a one-cycle verdict and enforces a retry
// limit with sticky lockout.
// Optional feature: define PIN_TIMEOUT_EN to build the COLLECT inactivity
// timeout; without it `timeout` is held at 0 and COLLECT waits indefinitely.
module pin_entry #(
    parameter int PIN_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            card_inserted,
    input  logic                            key_valid,
    input  logic [3:0]                      key_digit,
    input  logic                            key_enter,
    input  logic                            key_clear,
    input  logic [4*PIN_DIGITS-1:0]         stored_pin,
    output logic                            pin_done,
    output logic                            pin_correct,
    output logic                            locked,
    output logic                            timeout,
    output logic [$clog2(PIN_DIGITS+1)-1:0] digit_count
);

    localparam int BUF_W = 4 * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PIN_DIGITS);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        COMPARE,
        RESULT,
        WAIT_REMOVE,
        LOCKED
    } state_t;

    state_t             state_q, state_nxt;
    logic [BUF_W-1:0]   buf_q, buf_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [TRY_W-1:0]   tries_q, tries_nxt;
    logic [TRY_W-1:0]   tries_inc;
    logic               match_q, match_nxt;
    logic               done_q, done_nxt;
    logic               correct_q, correct_nxt;
    logic               locked_q, locked_nxt;
    logic               timeout_q, timeout_nxt;

`ifdef PIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]    idle_q, idle_nxt;
`endif

    // A keypad code is accepted as a digit only when it is valid BCD.
    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    assign tries_inc = tries_q + 1'b1;

    // Next-state, datapath and registered-output decode for the entry FSM.
    always_comb begin
        state_nxt   = state_q;
        buf_nxt     = buf_q;
        cnt_nxt     = cnt_q;
        tries_nxt   = tries_q;
        match_nxt   = match_q;
        done_nxt    = 1'b0;
        correct_nxt = 1'b0;
        locked_nxt  = locked_q;
        timeout_nxt = 1'b0;
`ifdef PIN_TIMEOUT_EN
        idle_nxt    = '0;
`endif

        case (state_q)
            IDLE: begin
                buf_nxt = '0;
                cnt_nxt = '0;
                if (card_inserted) begin
                    state_nxt = COLLECT;
                end
            end

            COLLECT: begin
                // Card removal beats every key; the try counter is kept.
                if (!card_inserted) begin
                    state_nxt = IDLE;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (key_clear) begin
                    buf_nxt = '0;
                    cnt_nxt = '0;
                end else if (key_enter) begin
                    state_nxt = COMPARE;
                end else if (key_valid) begin
                    // Non-BCD codes and digits beyond a full buffer are dropped.
                    if (digit_ok(key_digit) && (cnt_q < FULL_CNT)) begin
                        buf_nxt = (buf_q << 4) | BUF_W'(key_digit);
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
`ifdef PIN_TIMEOUT_EN
                else if (idle_q == TO_LAST) begin
                    // Abandoned entry: abort without a verdict or a try charge.
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                    buf_nxt     = '0;
                    cnt_nxt     = '0;
                end else begin
                    idle_nxt = idle_q + 1'b1;
                end
`endif
            end

            COMPARE: begin
                if (!card_inserted) begin
                    state_nxt = IDLE;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    // A short entry can never match, whatever the buffer holds.
                    match_nxt = (cnt_q == FULL_CNT) && (buf_q == stored_pin);
                    state_nxt = RESULT;
                end
            end

            RESULT: begin
                done_nxt    = 1'b1;
                correct_nxt = match_q;
                // The entered PIN is not kept once the verdict is out.
                buf_nxt     = '0;
                cnt_nxt     = '0;
                if (match_q) begin
                    tries_nxt = '0;
                    state_nxt = WAIT_REMOVE;
                end else begin
                    tries_nxt = tries_inc;
                    if (tries_inc >= TRY_LIMIT) begin
                        locked_nxt = 1'b1;
                        state_nxt  = LOCKED;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end

            WAIT_REMOVE: begin
                if (!card_inserted) begin
                    state_nxt = IDLE;
                end
            end

            LOCKED: begin
                locked_nxt = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, buffer, counters and all outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            tries_q   <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            correct_q <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            buf_q     <= buf_nxt;
            cnt_q     <= cnt_nxt;
            tries_q   <= tries_nxt;
            match_q   <= match_nxt;
            done_q    <= done_nxt;
            correct_q <= correct_nxt;
            locked_q  <= locked_nxt;
            timeout_q <= timeout_nxt;
        end
    end

`ifdef PIN_TIMEOUT_EN
    // Inactivity counter; cleared by any strobe and whenever COLLECT is left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_nxt;
        end
    end
`endif

    assign pin_done    = done_q;
    assign pin_correct = correct_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;
    assign digit_count = cnt_q;

endmodule
